// File: rtl/spi_i2s_pkg.sv
// Shared SPI/I2S definitions: word-length encodings, RX state encodings and
// the datlen -> bits-per-word mapping.
package spi_i2s_pkg;

  typedef enum logic [1:0] {
    DL_8  = 2'b00,
    DL_16 = 2'b01,
    DL_24 = 2'b10,
    DL_32 = 2'b11
  } datlen_e;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_e;

  localparam int WORD_W = 32;

  function automatic logic [5:0] word_len(input logic [1:0] dl);
    logic [5:0] n;
    case (datlen_e'(dl))
      DL_8:    n = 6'd8;
      DL_16:   n = 6'd16;
      DL_24:   n = 6'd24;
      default: n = 6'd32;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_i2s_rx_fifo.sv
// Synchronous DEPTH x 32 receive FIFO. A push into a full FIFO is dropped and
// flagged on drop, unless a pop happens in the same cycle.
module spi_i2s_rx_fifo
  import spi_i2s_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WORD_W-1:0] push_data,
  input  logic              pop,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       fill,
  output logic              drop
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              wr, rd;

  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign empty = (cnt_q == '0);
  assign fill  = cnt_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd       = pop && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    wr       = push && (!full || rd);
    drop     = push && !wr;
    wr_ptr_d = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge pclk) begin
    if (wr) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/spi_i2s_rx_ctrl.sv
// SPI/I2S receive control: assembles sampled bits into words and queues them
// for APB reads. Optional partial-word timeout under `RX_TIMEOUT_EN.
module spi_i2s_rx_ctrl
  import spi_i2s_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int AW     = 3,
  parameter int TO_CYC = 64
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              i2smod,
  input  logic              rx_en,
  input  logic [1:0]        datlen,
  input  logic              frm_start,
  input  logic              bit_vld,
  input  logic              bit_in,
  input  logic              rd_en,
  input  logic              ovr_clr,
  output logic [WORD_W-1:0] rd_data,
  output logic              rxne,
  output logic [AW:0]       rx_fill,
  output logic              ovr,
  output logic              bsy_rx,
  output logic              rx_to
);

  rx_state_e         state_q, state_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              push_q, push_d;
  logic              ovr_q, ovr_d;
  logic              rx_to_q, rx_to_d;
  logic [5:0]        base_cnt, cnt_nxt;
  logic [WORD_W-1:0] base_shift, shift_nxt;
  logic              take;
  logic              fifo_full, fifo_empty, fifo_drop;

  assign bsy_rx = (state_q == RX_SHIFT) && (bit_cnt_q != '0);

`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          unused_cfg;
  assign unused_cfg = i2smod;
`else
  logic unused_cfg;
  assign unused_cfg = i2smod ^ (TO_CYC != 0);
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    word_d     = word_q;
    push_d     = 1'b0;
    rx_to_d    = 1'b0;
    base_cnt   = bit_cnt_q;
    base_shift = shift_q;
    take       = 1'b0;
    cnt_nxt    = '0;
    shift_nxt  = '0;

    case (state_q)
      RX_IDLE: begin
        if (rx_en && frm_start) begin
          state_d    = RX_SHIFT;
          base_cnt   = '0;
          base_shift = '0;
          bit_cnt_d  = '0;
          shift_d    = '0;
          take       = bit_vld;
        end
      end
      default: begin
        if (!rx_en) begin
          state_d   = RX_IDLE;
          bit_cnt_d = '0;
          shift_d   = '0;
        end else begin
          // A frame boundary restarts the word before any same-cycle bit lands.
          if (frm_start) begin
            base_cnt   = '0;
            base_shift = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
          end
          take = bit_vld;
        end
      end
    endcase

    if (take) begin
      cnt_nxt   = base_cnt + 6'd1;
      shift_nxt = {base_shift[WORD_W-2:0], bit_in};
      if (cnt_nxt == word_len(datlen)) begin
        word_d    = shift_nxt;
        push_d    = 1'b1;
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        bit_cnt_d = cnt_nxt;
        shift_d   = shift_nxt;
      end
    end

`ifdef RX_TIMEOUT_EN
    to_cnt_d = '0;
    if (!bit_vld && !frm_start && bsy_rx) begin
      if (to_cnt_q == TW'(TO_CYC - 1)) begin
        rx_to_d   = 1'b1;
        state_d   = RX_IDLE;
        bit_cnt_d = '0;
        shift_d   = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
`endif

    ovr_d = ovr_clr ? 1'b0 : ovr_q;
    if (fifo_drop) ovr_d = 1'b1;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      word_q    <= '0;
      push_q    <= 1'b0;
      ovr_q     <= 1'b0;
      rx_to_q   <= 1'b0;
`ifdef RX_TIMEOUT_EN
      to_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      word_q    <= word_d;
      push_q    <= push_d;
      ovr_q     <= ovr_d;
      rx_to_q   <= rx_to_d;
`ifdef RX_TIMEOUT_EN
      to_cnt_q  <= to_cnt_d;
`endif
    end
  end

  assign ovr   = ovr_q;
  assign rx_to = rx_to_q;
  assign rxne  = !fifo_empty;

  spi_i2s_rx_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (word_q),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .fill      (rx_fill),
    .drop      (fifo_drop)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
